// File: rtl/pe_pkg.sv
// Shared definitions for the PE task sequencer.
//   state_e       : sequencer FSM states
//   PE_CTL_*      : bit positions inside the 2-bit pe_ctl beat flags
//   ERR_*         : bit positions inside the sticky err vector
package pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int PE_CTL_FIRST  = 0;
  localparam int PE_CTL_LAST   = 1;

  localparam int ERR_ZERO_LEN  = 0;
  localparam int ERR_UNEXP_VLD = 1;

endpackage

// File: rtl/pe_beat_cnt.sv
// Beat counter: walks the iterations of the current instruction and the
// shared neuron/weight address, producing the per-beat valid and first/last
// flags.
//   load_i      : reload address from base_addr_i and clear the iteration
//   base_addr_i : start address
//   run_i       : sequencer is issuing beats
//   stall_i     : hold the current beat
//   len_i       : iteration count of the current instruction
//   vld_o       : beat issued this cycle
//   ctl_o       : [PE_CTL_FIRST] first beat, [PE_CTL_LAST] last beat; 0 when no beat
//   addr_o      : current beat address
//   last_o      : the last beat of the instruction issues this cycle
module pe_beat_cnt
  import pe_pkg::*;
#(
  parameter int ITER_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              run_i,
  input  logic              stall_i,
  input  logic [ITER_W-1:0] len_i,
  output logic              vld_o,
  output logic [1:0]        ctl_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              len_nz;
  logic              is_last;

  // len_i - 1 only matters when len_i is non-zero, so the underflow of a
  // zero length never reaches the compare result.
  assign len_nz  = (len_i != '0);
  assign is_last = len_nz && (iter_q == (len_i - ITER_W'(1)));
  assign vld_o   = run_i && !stall_i && len_nz;
  assign last_o  = vld_o && is_last;
  assign addr_o  = addr_q;

  always_comb begin
    ctl_o = '0;
    if (vld_o) begin
      ctl_o[PE_CTL_FIRST] = (iter_q == '0);
      ctl_o[PE_CTL_LAST]  = is_last;
    end
  end

  always_comb begin
    iter_d = iter_q;
    addr_d = addr_q;
    if (load_i) begin
      iter_d = '0;
      addr_d = base_addr_i;
    end else if (vld_o) begin
      addr_d = addr_q + ADDR_W'(1);
      iter_d = is_last ? '0 : iter_q + ITER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_q <= '0;
      addr_q <= '0;
    end else begin
      iter_q <= iter_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/pe_task_seq.sv
// PE task sequencer: runs a list of instructions (each an iteration count),
// issues one neuron/weight beat per cycle to the MAC unit and collects one
// result per non-empty instruction into a result write port.
//   start/inst_num/base_addr : launch a program (accepted in IDLE only)
//   inst_addr/inst_data      : instruction memory read (combinational)
//   stall                    : hold the current beat
//   pe_vld_i/pe_ctl          : beat valid and first/last flags toward the PE
//   neuron_addr/weight_addr  : beat addresses
//   pe_vld_o/pe_result       : PE result return
//   res_we/res_addr/res_data : registered result write
//   busy/done/err            : status; err is sticky until the next start
module pe_task_seq
  import pe_pkg::*;
#(
  parameter int INST_DEPTH = 4,
  parameter int ITER_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int INST_AW    = (INST_DEPTH > 1) ? $clog2(INST_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INST_AW:0]   inst_num,
  input  logic [ADDR_W-1:0]  base_addr,
  output logic [INST_AW-1:0] inst_addr,
  input  logic [ITER_W-1:0]  inst_data,
  input  logic               stall,
  output logic               pe_vld_i,
  output logic [1:0]         pe_ctl,
  output logic [ADDR_W-1:0]  neuron_addr,
  output logic [ADDR_W-1:0]  weight_addr,
  input  logic               pe_vld_o,
  input  logic [DATA_W-1:0]  pe_result,
  output logic               res_we,
  output logic [INST_AW-1:0] res_addr,
  output logic [DATA_W-1:0]  res_data,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err
);

  localparam int CNT_W = INST_AW + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   inst_cnt_q, inst_cnt_d;
  logic [INST_AW-1:0] inst_addr_q, inst_addr_d;
  logic [CNT_W-1:0]   exp_cnt_q, exp_cnt_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
  logic               res_we_q, res_we_d;
  logic [INST_AW-1:0] res_addr_q, res_addr_d;
  logic [DATA_W-1:0]  res_data_q, res_data_d;
  logic [1:0]         err_q, err_d;

  logic               cnt_load;
  logic               run;
  logic               beat_last;
  logic [ADDR_W-1:0]  beat_addr;
  logic               final_inst;
  logic [CNT_W-1:0]   exp_lim;

  assign run = (state_q == ST_RUN);

  pe_beat_cnt #(
    .ITER_W (ITER_W),
    .ADDR_W (ADDR_W)
  ) u_beat_cnt (
    .clk         (clk),
    .rst         (rst),
    .load_i      (cnt_load),
    .base_addr_i (base_addr),
    .run_i       (run),
    .stall_i     (stall),
    .len_i       (inst_data),
    .vld_o       (pe_vld_i),
    .ctl_o       (pe_ctl),
    .addr_o      (beat_addr),
    .last_o      (beat_last)
  );

  // Neuron and weight streams advance in lockstep from the same base.
  assign neuron_addr = beat_addr;
  assign weight_addr = beat_addr;
  assign inst_addr   = inst_addr_q;
  assign res_we      = res_we_q;
  assign res_addr    = res_addr_q;
  assign res_data    = res_data_q;
  assign err         = err_q;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);

  assign final_inst = ({1'b0, inst_addr_q} == (inst_cnt_q - CNT_W'(1)));
  // A result may legally arrive in the same cycle as the last beat of its
  // instruction, before exp_cnt has been bumped.
  assign exp_lim    = exp_cnt_q + CNT_W'(beat_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    inst_cnt_d  = inst_cnt_q;
    inst_addr_d = inst_addr_q;
    exp_cnt_d   = exp_cnt_q;
    res_cnt_d   = res_cnt_q;
    res_we_d    = 1'b0;
    res_addr_d  = res_addr_q;
    res_data_d  = res_data_q;
    err_d       = err_q;
    cnt_load    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          inst_cnt_d  = inst_num;
          inst_addr_d = '0;
          exp_cnt_d   = '0;
          res_cnt_d   = '0;
          err_d       = '0;
          cnt_load    = 1'b1;
          state_d     = (inst_num == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Zero-length instructions are skipped without waiting for stall to
        // drop: no beat goes to the PE, so there is nothing to hold.
        if (inst_data == '0) begin
          err_d[ERR_ZERO_LEN] = 1'b1;
          inst_addr_d         = inst_addr_q + INST_AW'(1);
          if (final_inst) state_d = ST_DRAIN;
        end else if (beat_last) begin
          exp_cnt_d   = exp_cnt_q + CNT_W'(1);
          inst_addr_d = inst_addr_q + INST_AW'(1);
          if (final_inst) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (res_cnt_q == exp_cnt_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Result collection runs alongside beat issue.
    if (pe_vld_o) begin
      if (busy && (res_cnt_q < exp_lim)) begin
        res_we_d   = 1'b1;
        res_addr_d = res_cnt_q[INST_AW-1:0];
        res_data_d = pe_result;
        res_cnt_d  = res_cnt_q + CNT_W'(1);
      end else begin
        err_d[ERR_UNEXP_VLD] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_cnt_q  <= '0;
      inst_addr_q <= '0;
      exp_cnt_q   <= '0;
      res_cnt_q   <= '0;
      res_we_q    <= 1'b0;
      res_addr_q  <= '0;
      res_data_q  <= '0;
      err_q       <= '0;
    end else begin
      inst_cnt_q  <= inst_cnt_d;
      inst_addr_q <= inst_addr_d;
      exp_cnt_q   <= exp_cnt_d;
      res_cnt_q   <= res_cnt_d;
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_pe_task_seq.sv
module tb_pe_task_seq;

  localparam int INST_DEPTH = 4;
  localparam int ITER_W     = 8;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int INST_AW    = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [INST_AW:0]   inst_num;
  logic [ADDR_W-1:0]  base_addr;
  logic [INST_AW-1:0] inst_addr;
  logic [ITER_W-1:0]  inst_data;
  logic               stall;
  logic               pe_vld_i;
  logic [1:0]         pe_ctl;
  logic [ADDR_W-1:0]  neuron_addr;
  logic [ADDR_W-1:0]  weight_addr;
  logic               pe_vld_o;
  logic [DATA_W-1:0]  pe_result;
  logic               res_we;
  logic [INST_AW-1:0] res_addr;
  logic [DATA_W-1:0]  res_data;
  logic               busy;
  logic               done;
  logic [1:0]         err;

  logic [ITER_W-1:0]  prog_mem [0:INST_DEPTH-1];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        ctl;
    int                idx;
  } beat_t;

  int checks   = 0;
  int failures = 0;

  assign inst_data = prog_mem[inst_addr];

  always #5 clk = ~clk;

  pe_task_seq #(
    .INST_DEPTH (INST_DEPTH),
    .ITER_W     (ITER_W),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .inst_num    (inst_num),
    .base_addr   (base_addr),
    .inst_addr   (inst_addr),
    .inst_data   (inst_data),
    .stall       (stall),
    .pe_vld_i    (pe_vld_i),
    .pe_ctl      (pe_ctl),
    .neuron_addr (neuron_addr),
    .weight_addr (weight_addr),
    .pe_vld_o    (pe_vld_o),
    .pe_result   (pe_result),
    .res_we      (res_we),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".pe_vld_i"}, 64'(pe_vld_i), 64'd0);
    chk({tag, ".pe_ctl"}, 64'(pe_ctl), 64'd0);
    chk({tag, ".neuron_addr"}, 64'(neuron_addr), 64'd0);
    chk({tag, ".weight_addr"}, 64'(weight_addr), 64'd0);
    chk({tag, ".inst_addr"}, 64'(inst_addr), 64'd0);
    chk({tag, ".res_we"}, 64'(res_we), 64'd0);
    chk({tag, ".res_addr"}, 64'(res_addr), 64'd0);
    chk({tag, ".res_data"}, 64'(res_data), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk({tag, ".err"}, 64'(err), 64'd0);
  endtask

  // stall_mode: 0 never, 1 every third cycle, 2 random.
  // abort_at > 0: assert rst right after that many beats have been seen.
  task automatic run_prog(input int n, input logic [ADDR_W-1:0] base,
                          input int stall_mode, input int abort_at);
    beat_t             exp_q[$];
    logic [DATA_W-1:0] sent_q[$];
    int                pend_t[$];
    logic [DATA_W-1:0] pend_v[$];
    beat_t             b;
    logic [ADDR_W-1:0] a;
    int                nres_exp = 0;
    logic              zero_seen = 1'b0;
    int                total, cyc, beats, res_idx, first, last, last_ready, len;
    logic              done_seen, aborted;

    // Reference: flatten the program into its beat list.
    a = base;
    for (int i = 0; i < n; i++) begin
      len = int'(prog_mem[i]);
      if (len == 0) zero_seen = 1'b1;
      else nres_exp++;
      for (int j = 0; j < len; j++) begin
        b.addr = a;
        b.ctl  = {(j == len - 1), (j == 0)};
        b.idx  = i;
        exp_q.push_back(b);
        a = a + 1'b1;
      end
    end
    total      = exp_q.size();
    cyc        = 0;
    beats      = 0;
    res_idx    = 0;
    first      = -1;
    last       = -1;
    last_ready = 0;
    done_seen  = 1'b0;
    aborted    = 1'b0;

    @(posedge clk); #1;
    start     = 1'b1;
    inst_num  = (INST_AW+1)'(n);
    base_addr = base;
    while (cyc < 600 && !done_seen && !aborted) begin
      case (stall_mode)
        1:       stall = (cyc % 3 == 2);
        2:       stall = ($urandom_range(0, 3) == 0);
        default: stall = 1'b0;
      endcase
      if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
        pe_vld_o  = 1'b1;
        pe_result = pend_v.pop_front();
        void'(pend_t.pop_front());
      end else begin
        pe_vld_o  = 1'b0;
        pe_result = $urandom;
      end
      @(negedge clk);
      if (res_we) begin
        chk("res_addr", 64'(res_addr), 64'(res_idx % INST_DEPTH));
        if (sent_q.size() > 0) chk("res_data", 64'(res_data), 64'(sent_q.pop_front()));
        else chk("res_we_spurious", 64'(res_we), 64'd0);
        res_idx++;
      end
      if (pe_vld_o) sent_q.push_back(pe_result);
      if (pe_vld_i) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'(pe_vld_i), 64'd0);
        end else begin
          b = exp_q.pop_front();
          chk("neuron_addr", 64'(neuron_addr), 64'(b.addr));
          chk("weight_addr", 64'(weight_addr), 64'(b.addr));
          chk("pe_ctl", 64'(pe_ctl), 64'(b.ctl));
          chk("inst_addr", 64'(inst_addr), 64'(b.idx));
        end
        beats++;
        if (first < 0) first = cyc;
        last = cyc;
        if (pe_ctl[1]) begin
          last_ready = (cyc + 1 > last_ready ? cyc + 1 : last_ready) + $urandom_range(0, 2);
          pend_t.push_back(last_ready);
          pend_v.push_back($urandom);
        end
        if (abort_at > 0 && beats == abort_at) begin
          rst = 1'b1;
          #1;
          check_reset_vals("abort");
          aborted = 1'b1;
        end
      end
      if (done) begin
        done_seen = 1'b1;
        chk("busy_at_done", 64'(busy), 64'd0);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    pe_vld_o = 1'b0;
    stall    = 1'b0;
    if (aborted) begin
      chk("abort_no_done", 64'(done_seen), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_reset_vals("post_abort");
    end else begin
      chk("done_seen", 64'(done_seen), 64'd1);
      chk("beats_left", 64'(exp_q.size()), 64'd0);
      chk("beat_count", 64'(beats), 64'(total));
      chk("res_count", 64'(res_idx), 64'(nres_exp));
      if (stall_mode == 0 && total > 0 && !zero_seen)
        chk("beat_span", 64'(last - first + 1), 64'(total));
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("busy_after", 64'(busy), 64'd0);
      chk("err_after", 64'(err), 64'({1'b0, zero_seen}));
      chk("res_we_after", 64'(res_we), 64'd0);
    end
  endtask

  task automatic load_prog(input int l0, input int l1, input int l2, input int l3);
    prog_mem[0] = ITER_W'(l0);
    prog_mem[1] = ITER_W'(l1);
    prog_mem[2] = ITER_W'(l2);
    prog_mem[3] = ITER_W'(l3);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    inst_num  = '0;
    base_addr = '0;
    stall     = 1'b0;
    pe_vld_o  = 1'b0;
    pe_result = '0;
    load_prog(0, 0, 0, 0);
    #12;
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic program, no stall: 14 consecutive beats.
    load_prog(3, 5, 2, 4);
    run_prog(4, 16'h0000, 0, 0);

    // Same program stretched by a periodic stall.
    run_prog(4, 16'h0000, 1, 0);

    // Single-beat and zero-length instructions.
    load_prog(1, 0, 2, 0);
    run_prog(3, 16'h0000, 0, 0);

    // Address wrap.
    load_prog(4, 0, 0, 0);
    run_prog(1, 16'hFFFE, 0, 0);

    // Empty program goes straight to done.
    run_prog(0, 16'h1234, 0, 0);

    // Stray PE result while idle.
    @(posedge clk); #1;
    pe_vld_o  = 1'b1;
    pe_result = 32'hDEADBEEF;
    @(posedge clk); #1;
    pe_vld_o = 1'b0;
    @(negedge clk);
    chk("idle_vld_err", 64'(err), 64'd2);
    chk("idle_vld_no_we", 64'(res_we), 64'd0);
    load_prog(2, 3, 0, 0);
    run_prog(2, 16'h0100, 0, 0);

    // Reset in the middle of a run, then a clean rerun.
    load_prog(3, 5, 2, 4);
    run_prog(4, 16'h0040, 0, 5);
    run_prog(4, 16'h0040, 0, 0);

    // Randomised programs with random stall.
    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(0, INST_DEPTH));
      load_prog(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
      run_prog(n, ADDR_W'($urandom), 2, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
